// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared types and helpers for the lfsr_gen pseudo-random source.
//   lfsr_state_t    : warm-up / run FSM encoding
//   DEFAULT_TAPS_10 : maximal-length taps for the legacy 10-bit LFSR (q[0], q[3])
//   step_t          : result of one LFSR step (next value + lock-up hit flag)
//   lfsr_step()     : one Fibonacci XNOR step with all-ones -> zero substitution
// -----------------------------------------------------------------------------
package lfsr_pkg;

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } lfsr_state_t;

    localparam logic [9:0] DEFAULT_TAPS_10 = 10'h009;

    typedef struct packed {
        logic [31:0] value;
        logic        hit;
    } step_t;

    // The function works on a 32-bit container so one definition serves every
    // WIDTH; bits at and above `width` are always returned as zero.
    function automatic step_t lfsr_step(input logic [31:0] q,
                                        input logic [31:0] taps,
                                        input int          width);
        logic [31:0] mask;
        logic        fb;
        step_t       r;
        mask    = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        fb      = ~^(q & taps & mask);
        r.value = ((q & mask) >> 1) | ({31'd0, fb} << (width - 1));
        // All-ones is the XNOR lock-up state: replace it with the legal zero.
        r.hit   = (r.value == mask);
        if (r.hit) begin
            r.value = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/lfsr_gen.sv
// -----------------------------------------------------------------------------
// lfsr_gen
// Parametrised Fibonacci XNOR LFSR with multi-step advance, seed load, warm-up
// discard and lock-up recovery.
//
// Parameters:
//   WIDTH  (3..32)      register width
//   TAPS                feedback mask, bit i set -> q[i] enters the XNOR
//   STEPS  (1..WIDTH)   shifts applied per enabled cycle
//   WARMUP (0..255)     enabled cycles discarded before `valid`
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   en          in   advance the LFSR by STEPS this cycle
//   load        in   load `seed` this cycle (wins over en)
//   seed        in   seed value [WIDTH]
//   q           out  current LFSR state [WIDTH]
//   valid       out  q is past warm-up
//   lockup      out  one-cycle pulse: all-ones state intercepted
//
// Optional (macro LFSR_PERIOD_EN):
//   period_hit  out  pulses when q returns to the value latched at reset/load
//   period_cnt  out  steps between start value and its recurrence [WIDTH]
// -----------------------------------------------------------------------------
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int          WIDTH  = 10,
    parameter logic [31:0] TAPS   = 32'(DEFAULT_TAPS_10),
    parameter int          STEPS  = 1,
    parameter int          WARMUP = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic             lockup
`ifdef LFSR_PERIOD_EN
    ,
    output logic             period_hit,
    output logic [WIDTH-1:0] period_cnt
`endif
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
        $error("lfsr_gen: WIDTH must be in 3..32");
    end
    if (TAPS == 32'd0) begin : g_bad_taps_zero
        $error("lfsr_gen: TAPS must be non-zero");
    end
    if (WIDTH < 32 && TAPS >= (32'd1 << WIDTH)) begin : g_bad_taps_range
        $error("lfsr_gen: TAPS must fit in WIDTH bits");
    end
    if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
        $error("lfsr_gen: STEPS must be in 1..WIDTH");
    end
    if (WARMUP < 0 || WARMUP > 255) begin : g_bad_warmup
        $error("lfsr_gen: WARMUP must be in 0..255");
    end

    localparam logic [7:0]  WCNT_INIT  = 8'(WARMUP);
    localparam lfsr_state_t STATE_INIT = (WARMUP == 0) ? lfsr_pkg::RUN : lfsr_pkg::WARMUP;

    // ------------------------------------------------------------------------
    // Combinational STEPS-deep step chain. Each stage applies the lock-up
    // substitution, so an intercepted intermediate continues from zero.
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < STEPS; i++) begin : g_step
        logic [WIDTH-1:0] cur;
        logic             hit_in;
        step_t            r;
        logic [WIDTH-1:0] nxt;
        logic             hit_out;

        if (i == 0) begin : g_first
            assign cur    = q;
            assign hit_in = 1'b0;
        end else begin : g_chain
            assign cur    = g_step[i-1].nxt;
            assign hit_in = g_step[i-1].hit_out;
        end

        assign r       = lfsr_step(32'(cur), TAPS, WIDTH);
        assign nxt     = r.value[WIDTH-1:0];
        assign hit_out = hit_in | r.hit;

        // Upper container bits are always zero; sink them explicitly.
        if (WIDTH < 32) begin : g_sink
            logic unused_hi;
            assign unused_hi = ^r.value[31:WIDTH];
        end
    end

    logic [WIDTH-1:0] step_q;
    logic             step_hit;
    logic             seed_forbidden;

    assign step_q         = g_step[STEPS-1].nxt;
    assign step_hit       = g_step[STEPS-1].hit_out;
    assign seed_forbidden = &seed;

    // ------------------------------------------------------------------------
    // LFSR register: reset > load > en > hold
    // ------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking (<=) so every register samples the
    // pre-edge values of its peers; blocking here would create ordering races.
    always_ff @(posedge clk) begin
        if (reset) begin
            q      <= '0;
            lockup <= 1'b0;
        end else if (load) begin
            q      <= seed_forbidden ? '0 : seed;
            lockup <= seed_forbidden;
        end else if (en) begin
            q      <= step_q;
            lockup <= step_hit;
        end else begin
            lockup <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Warm-up FSM: state register / next-state logic / output logic
    // ------------------------------------------------------------------------
    lfsr_state_t state, state_next;
    logic [7:0]  wcnt, wcnt_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= STATE_INIT;
            wcnt  <= WCNT_INIT;
        end else begin
            state <= state_next;
            wcnt  <= wcnt_next;
        end
    end

    // NOTE: defaults at the top of the block give every path an assignment,
    // so no latch is inferred for the hold case.
    always_comb begin
        state_next = state;
        wcnt_next  = wcnt;
        if (load) begin
            state_next = STATE_INIT;
            wcnt_next  = WCNT_INIT;
        end else if (en && state == lfsr_pkg::WARMUP) begin
            wcnt_next = wcnt - 8'd1;
            if (wcnt == 8'd1) begin
                state_next = lfsr_pkg::RUN;
            end
        end
    end

    // valid comes straight from the state register: no input-to-output path.
    always_comb begin
        valid = (state == lfsr_pkg::RUN);
    end

`ifdef LFSR_PERIOD_EN
    // ------------------------------------------------------------------------
    // Period measurement: compare the next q against the start value latched
    // at reset/load, counting steps in between.
    // ------------------------------------------------------------------------
    localparam logic [WIDTH-1:0] STEP_INC = WIDTH'(STEPS);

    logic [WIDTH-1:0] start_val;
    logic [WIDTH-1:0] run_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            start_val  <= '0;
            run_cnt    <= '0;
            period_hit <= 1'b0;
            period_cnt <= '0;
        end else if (load) begin
            start_val  <= seed_forbidden ? '0 : seed;
            run_cnt    <= '0;
            period_hit <= 1'b0;
        end else if (en) begin
            if (step_q == start_val) begin
                period_hit <= 1'b1;
                period_cnt <= run_cnt + STEP_INC;
                run_cnt    <= '0;
            end else begin
                period_hit <= 1'b0;
                run_cnt    <= run_cnt + STEP_INC;
            end
        end else begin
            period_hit <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// -----------------------------------------------------------------------------
// tb_lfsr_gen
// Scoreboard bench for lfsr_gen. A driver applies one directed vector per
// cycle on the falling edge and queues the hand-computed state expected after
// the next rising edge; a monitor pops and compares #1 after each rising edge.
// Two DUTs share the stimulus: defaults (STEPS=1) and STEPS=3.
// With LFSR_PERIOD_EN defined, a free-running phase checks period_hit/cnt.
// -----------------------------------------------------------------------------
module tb_lfsr_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [9:0] seed = '0;

    logic [9:0] q, q3;
    logic       valid, valid3, lockup, lockup3;
`ifdef LFSR_PERIOD_EN
    logic       period_hit, period_hit3;
    logic [9:0] period_cnt, period_cnt3;
`endif

    always #5 clk = ~clk;

    lfsr_gen dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .load      (load),
        .seed      (seed),
        .q         (q),
        .valid     (valid),
        .lockup    (lockup)
`ifdef LFSR_PERIOD_EN
        ,
        .period_hit(period_hit),
        .period_cnt(period_cnt)
`endif
    );

    lfsr_gen #(.STEPS(3)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .load      (load),
        .seed      (seed),
        .q         (q3),
        .valid     (valid3),
        .lockup    (lockup3)
`ifdef LFSR_PERIOD_EN
        ,
        .period_hit(period_hit3),
        .period_cnt(period_cnt3)
`endif
    );

    typedef struct {
        int         id;
        logic       chk_q;
        logic [9:0] q;
        logic       valid;
        logic       lockup;
        logic       chk3;
        logic [9:0] q3;
        logic       chk_p;
        logic       hit;
        logic [9:0] pcnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    task automatic check(input string name, input int id,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s vec%0d: got 0x%0h, expected 0x%0h", name, id, act, exp);
        end
    endtask

    function automatic exp_t mk(input int id, input logic [9:0] eq, input logic ev,
                                input logic elk, input logic c3, input logic [9:0] eq3);
        exp_t x;
        x.id     = id;
        x.chk_q  = 1'b1;
        x.q      = eq;
        x.valid  = ev;
        x.lockup = elk;
        x.chk3   = c3;
        x.q3     = eq3;
        x.chk_p  = 1'b0;
        x.hit    = 1'b0;
        x.pcnt   = '0;
        return x;
    endfunction

    task automatic apply(input logic r, input logic e, input logic l,
                         input logic [9:0] s, input exp_t x);
        @(negedge clk);
        reset = r;
        en    = e;
        load  = l;
        seed  = s;
        sb.push_back(x);
    endtask

    // Monitor: every rising edge with a pending expectation is one observation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                if (e.chk_q) check("q", e.id, 32'(q), 32'(e.q));
                check("valid", e.id, 32'(valid), 32'(e.valid));
                check("lockup", e.id, 32'(lockup), 32'(e.lockup));
                if (e.chk3) check("q_steps3", e.id, 32'(q3), 32'(e.q3));
`ifdef LFSR_PERIOD_EN
                if (e.chk_p) begin
                    check("period_hit", e.id, 32'(period_hit), 32'(e.hit));
                    if (e.hit) check("period_cnt", e.id, 32'(period_cnt), 32'(e.pcnt));
                end
`endif
            end
        end
    end

    initial begin
        //     reset en load seed            id  q       v     lk    c3    q3
        apply(1'b1, 1'b0, 1'b0, 10'h000, mk( 1, 10'h000, 1'b0, 1'b0, 1'b1, 10'h000));
        apply(1'b1, 1'b0, 1'b0, 10'h000, mk( 2, 10'h000, 1'b0, 1'b0, 1'b1, 10'h000));
        apply(1'b0, 1'b1, 1'b0, 10'h000, mk( 3, 10'h200, 1'b0, 1'b0, 1'b1, 10'h380));
        apply(1'b0, 1'b1, 1'b0, 10'h000, mk( 4, 10'h300, 1'b0, 1'b0, 1'b1, 10'h3F0));
        apply(1'b0, 1'b0, 1'b0, 10'h000, mk( 5, 10'h300, 1'b0, 1'b0, 1'b1, 10'h3F0));
        apply(1'b0, 1'b1, 1'b0, 10'h000, mk( 6, 10'h380, 1'b0, 1'b0, 1'b1, 10'h0FE));
        apply(1'b0, 1'b1, 1'b0, 10'h000, mk( 7, 10'h3C0, 1'b1, 1'b0, 1'b1, 10'h31F));
        apply(1'b0, 1'b1, 1'b0, 10'h000, mk( 8, 10'h3E0, 1'b1, 1'b0, 1'b0, 10'h000));
        // Forbidden seed with en: intercepted to zero, lockup pulse, warm-up restarts.
        apply(1'b0, 1'b1, 1'b1, 10'h3FF, mk( 9, 10'h000, 1'b0, 1'b1, 1'b1, 10'h000));
        apply(1'b0, 1'b0, 1'b0, 10'h000, mk(10, 10'h000, 1'b0, 1'b0, 1'b1, 10'h000));
        apply(1'b0, 1'b0, 1'b1, 10'h155, mk(11, 10'h155, 1'b0, 1'b0, 1'b1, 10'h155));
        apply(1'b0, 1'b1, 1'b0, 10'h000, mk(12, 10'h0AA, 1'b0, 1'b0, 1'b0, 10'h000));
        apply(1'b0, 1'b1, 1'b0, 10'h000, mk(13, 10'h055, 1'b0, 1'b0, 1'b0, 10'h000));
        apply(1'b0, 1'b1, 1'b0, 10'h000, mk(14, 10'h02A, 1'b0, 1'b0, 1'b0, 10'h000));
        apply(1'b0, 1'b1, 1'b0, 10'h000, mk(15, 10'h015, 1'b1, 1'b0, 1'b0, 10'h000));
        // Load in RUN together with en: seed taken, no step, valid drops.
        apply(1'b0, 1'b1, 1'b1, 10'h123, mk(16, 10'h123, 1'b0, 1'b0, 1'b1, 10'h123));
        apply(1'b0, 1'b0, 1'b0, 10'h000, mk(17, 10'h123, 1'b0, 1'b0, 1'b0, 10'h000));
        apply(1'b0, 1'b1, 1'b0, 10'h000, mk(18, 10'h091, 1'b0, 1'b0, 1'b0, 10'h000));
        apply(1'b0, 1'b1, 1'b0, 10'h000, mk(19, 10'h048, 1'b0, 1'b0, 1'b0, 10'h000));
        apply(1'b0, 1'b1, 1'b0, 10'h000, mk(20, 10'h024, 1'b0, 1'b0, 1'b0, 10'h000));
        apply(1'b0, 1'b0, 1'b0, 10'h000, mk(21, 10'h024, 1'b0, 1'b0, 1'b0, 10'h000));
        apply(1'b0, 1'b1, 1'b0, 10'h000, mk(22, 10'h212, 1'b1, 1'b0, 1'b0, 10'h000));
        // Reset mid-warm-up with en high: full warm-up restarts from zero.
        apply(1'b0, 1'b0, 1'b1, 10'h155, mk(23, 10'h155, 1'b0, 1'b0, 1'b0, 10'h000));
        apply(1'b0, 1'b1, 1'b0, 10'h000, mk(24, 10'h0AA, 1'b0, 1'b0, 1'b0, 10'h000));
        apply(1'b1, 1'b1, 1'b0, 10'h000, mk(25, 10'h000, 1'b0, 1'b0, 1'b1, 10'h000));
        apply(1'b0, 1'b1, 1'b0, 10'h000, mk(26, 10'h200, 1'b0, 1'b0, 1'b0, 10'h000));
        apply(1'b0, 1'b1, 1'b0, 10'h000, mk(27, 10'h300, 1'b0, 1'b0, 1'b0, 10'h000));
        apply(1'b0, 1'b1, 1'b0, 10'h000, mk(28, 10'h380, 1'b0, 1'b0, 1'b0, 10'h000));
        apply(1'b0, 1'b1, 1'b0, 10'h000, mk(29, 10'h3C0, 1'b1, 1'b0, 1'b0, 10'h000));

`ifdef LFSR_PERIOD_EN
        // Free run from reset: q returns to 0 after 1023 steps, twice.
        apply(1'b1, 1'b0, 1'b0, 10'h000, mk(1000, 10'h000, 1'b0, 1'b0, 1'b0, 10'h000));
        for (int k = 1; k <= 2046; k++) begin
            exp_t x;
            x       = mk(1000 + k, 10'h000, (k >= 4), 1'b0, 1'b0, 10'h000);
            x.chk_q = (k == 1023) || (k == 2046);
            x.chk_p = 1'b1;
            x.hit   = (k == 1023) || (k == 2046);
            x.pcnt  = 10'd1023;
            apply(1'b0, 1'b1, 1'b0, 10'h000, x);
        end
`endif

        @(negedge clk);
        en = 1'b0;
        for (int t = 0; t < 20 && sb.size() > 0; t++) begin
            @(negedge clk);
        end
        if (sb.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
- Parametrised Fibonacci XNOR LFSR pseudo-random source; next generation of the team's fixed 10-bit LFSR.
- Adds configurable width and taps, multiple steps per cycle, seed load, step enable, warm-up discard, and lock-up recovery.
- Feeds game-logic blocks (random spawn, AI moves) with a `valid` qualifier.

Parameters:
- WIDTH, 10, register width in bits (3..32).
- TAPS, 10'h009, feedback mask; bit i set means q[i] enters the XNOR feedback. Default taps q[0], q[3] give maximal period 1023.
- STEPS, 1, LFSR shifts applied per enabled cycle (1..WIDTH).
- WARMUP, 4, enabled cycles discarded after reset or load before `valid` asserts (0..255).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  advance the LFSR by STEPS this cycle.
- load  in  1  load `seed` this cycle.
- seed  in  WIDTH  seed value, sampled when `load`=1.
- q  out  WIDTH  current LFSR state.
- valid  out  1  q is past warm-up and usable.
- lockup  out  1  one-cycle pulse: forbidden all-ones state intercepted.

Behaviour:
- Single step: fb = ~^(q & TAPS); q_next = {fb, q[WIDTH-1:1]} (shift right, feedback enters MSB). STEPS steps are chained combinationally within one cycle.
- Forbidden state: all-ones, the XNOR lock-up. All-zeros is legal.
- Priority: reset > load > en > hold.
- Reset: q=0, valid=0, lockup=0, FSM enters WARMUP with wcnt=WARMUP. If WARMUP=0, FSM enters RUN directly.
- FSM states:
  - WARMUP: each en cycle steps q and decrements wcnt. When an en cycle sees wcnt==1, next state is RUN.
  - RUN: each en cycle steps q.
- valid: registered, equals (state==RUN). It rises on the clock edge that ends the final warm-up step.
- Load, in any state:
  - q <= seed; state <= WARMUP with wcnt=WARMUP (RUN if WARMUP=0); valid drops the next cycle.
  - en in the same cycle is ignored.
- Lock-up interception: if the value about to be written to q (a loaded seed, or any intermediate or final step result) is all-ones, q <= 0 instead and lockup=1 for exactly that cycle. Otherwise lockup=0.
- Hold: en=0 and load=0 leaves q, state and wcnt unchanged.
- Reset mid-warm-up or mid-run behaves exactly as reset from power-up.
- Latency: q reflects en/load on the next rising edge. No combinational path from inputs to outputs.
- Parameter check: elaboration error if TAPS==0, TAPS >= 2**WIDTH, or STEPS is outside 1..WIDTH.

Optional Feature:
- Macro: LFSR_PERIOD_EN.
- Defined:
  - Adds output `period_hit` (1 bit). It pulses one cycle when q returns to the start value latched at the last reset or load.
  - Adds output `period_cnt` (WIDTH bits). It holds the step count between the start value and its recurrence, latched when `period_hit` fires; the running counter then restarts at 0.
  - Both outputs are 0 at reset.
- Undefined: neither port nor the counter or comparator exists; all other behaviour is identical.

Decomposition:
- Package lfsr_pkg holds:
  - typedef enum lfsr_state_t {WARMUP, RUN};
  - localparam DEFAULT_TAPS_10 = 10'h009;
  - function lfsr_step(q, taps), a single XNOR step with all-ones to 0 substitution.
- No sub-module. The step function is unrolled STEPS times in a generate loop inside lfsr_gen.

Test Plan:
- Reset then en=1 for 2 cycles (defaults): q goes 0x000 → 0x200 → 0x300. valid stays 0 until the 4th en cycle after reset, then 1.
- load=1 with seed=0x3FF: next q=0x000, lockup=1 for one cycle, valid=0. A load with seed=0x155 yields q=0x155 and lockup=0.
- STEPS=3: from q=0, one en cycle gives q=0x380, equal to three single steps (0x200, 0x300, 0x380).
- load asserted in RUN together with en=1: q=seed (no step), valid drops next cycle and returns after 4 en cycles. en=0 gaps freeze wcnt.
- reset asserted mid-warm-up with en=1: q=0, FSM restarts full warm-up. The next en step gives q=0x200.
- LFSR_PERIOD_EN defined, defaults, en held high from reset: period_hit pulses with period_cnt=1023 and repeats every 1023 cycles. lockup never fires.
